hazard_stall_ctrl: RTL

//  Pipeline hazard/stall controller for the 5-stage core. Decodes instructions held in the
//  D, E and M pipeline registers and issues stall (PC + F/D hold) and flush_DE (bubble into D/E).

---
 rtl/hazard_pkg.sv | 50 +++++
 rtl/md_busy_timer.sv | 69 ++++++
 rtl/hazard_stall_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode/funct constants, mult/div FSM state type and decode helpers
// for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // mult, multu, div, divu: the ops that occupy the unit
    function automatic logic is_mult_div(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) &&
               ((funct == FN_MULT) || (funct == FN_MULTU) ||
                (funct == FN_DIV)  || (funct == FN_DIVU));
    endfunction

    function automatic logic is_div_op(input logic [5:0] funct);
        return (funct == FN_DIV) || (funct == FN_DIVU);
    endfunction

    // Any op that must wait for the unit: mult*/div* plus HI/LO moves
    function automatic logic is_md_class(input logic [5:0] op, input logic [5:0] funct);
        return is_mult_div(op, funct) ||
               ((op == OP_RTYPE) &&
                ((funct == FN_MFHI) || (funct == FN_MTHI) ||
                 (funct == FN_MFLO) || (funct == FN_MTLO)));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div unit occupancy FSM: IDLE/BUSY with a registered down-counter of
// remaining busy cycles. Starts are ignored while BUSY.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    md_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    // IDLE/BUSY state machine with down-counter and registered busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= MD_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (start) begin
                        state_r <= MD_BUSY;
                        busy_r  <= 1'b1;
                        cnt_r   <= is_div ? DIV_LOAD : MULT_LOAD;
                    end else begin
                        state_r <= MD_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                MD_BUSY: begin
                    if (cnt_r <= CNT_ONE) begin
                        state_r <= MD_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= MD_BUSY;
                        busy_r  <= 1'b1;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= MD_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign cnt  = cnt_r;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch-on-load-in-M and mult/div
// busy stalls. Optional stall-cycle performance counter under STALL_PERF_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr_D,
    input  logic [31:0]      instr_E,
    input  logic [31:0]      instr_M,
    output logic             stall,
    output logic             flush_DE,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt,
    output logic [31:0]      perf_stall_cnt
);

    logic [5:0] op_d_s, funct_d_s, op_e_s, funct_e_s, op_m_s;
    logic [4:0] rs_d_s, rt_d_s, rt_e_s, rt_m_s;
    logic       reads_rs_s, reads_rt_s;
    logic       load_use_s, branch_m_s, md_stall_s;
    logic       md_start_s, is_div_e_s, timer_busy_s, stall_s;
    logic       unused_s;

    assign op_d_s    = instr_D[31:26];
    assign rs_d_s    = instr_D[25:21];
    assign rt_d_s    = instr_D[20:16];
    assign funct_d_s = instr_D[5:0];
    assign op_e_s    = instr_E[31:26];
    assign rt_e_s    = instr_E[20:16];
    assign funct_e_s = instr_E[5:0];
    assign op_m_s    = instr_M[31:26];
    assign rt_m_s    = instr_M[20:16];
    assign unused_s  = ^{instr_D[15:6], instr_E[25:21], instr_E[15:6],
                         instr_M[25:21], instr_M[15:0]};

    // Register-read decode of the instruction in D
    always_comb begin
        reads_rs_s = 1'b1;
        reads_rt_s = 1'b0;
        if ((op_d_s == OP_J) || (op_d_s == OP_JAL) || (op_d_s == OP_LUI)) begin
            reads_rs_s = 1'b0;
        end else if ((op_d_s == OP_RTYPE) &&
                     ((funct_d_s == FN_SLL) || (funct_d_s == FN_SRL) ||
                      (funct_d_s == FN_SRA))) begin
            reads_rs_s = 1'b0;
        end else begin
            reads_rs_s = 1'b1;
        end
        if ((op_d_s == OP_RTYPE) || (op_d_s == OP_BEQ) ||
            (op_d_s == OP_BNE)   || (op_d_s == OP_SW)) begin
            reads_rt_s = 1'b1;
        end else begin
            reads_rt_s = 1'b0;
        end
    end

    // Hazard terms; $0 destinations never create a dependency
    always_comb begin
        load_use_s = 1'b0;
        branch_m_s = 1'b0;
        if ((op_e_s == OP_LW) && (rt_e_s != 5'd0)) begin
            load_use_s = (reads_rs_s && (rs_d_s == rt_e_s)) ||
                         (reads_rt_s && (rt_d_s == rt_e_s));
        end else begin
            load_use_s = 1'b0;
        end
        if (((op_d_s == OP_BEQ) || (op_d_s == OP_BNE)) &&
            (op_m_s == OP_LW) && (rt_m_s != 5'd0)) begin
            branch_m_s = (rs_d_s == rt_m_s) || (rt_d_s == rt_m_s);
        end else begin
            branch_m_s = 1'b0;
        end
    end

    // A mult/div arriving in E while BUSY is malformed and must not restart the unit
    assign md_start_s = is_mult_div(op_e_s, funct_e_s) && !timer_busy_s;
    assign is_div_e_s = is_div_op(funct_e_s);
    assign md_stall_s = is_md_class(op_d_s, funct_d_s) && (timer_busy_s || md_start_s);
    assign stall_s    = load_use_s | branch_m_s | md_stall_s;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start_s),
        .is_div  (is_div_e_s),
        .busy    (timer_busy_s),
        .cnt     (md_cnt)
    );

    assign stall    = stall_s;
    assign flush_DE = stall_s;
    assign md_start = md_start_s;
    assign md_busy  = timer_busy_s | md_start_s;

`ifdef STALL_PERF_EN
    logic [31:0] perf_r;

    // Saturating count of edges on which the pipeline was stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_r <= 32'h0000_0000;
        end else if (stall_s && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_stall_cnt = perf_r;
`else
    assign perf_stall_cnt = 32'h0000_0000;
`endif

endmodule
